// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared state and size encodings for the data/instruction bus access units
//
// Purpose: state encodings for the bus access FSM and the bus transfer size codes.
// The instruction-side fetch unit imports the same definitions.
// Ports: none (package).

package mem_access_pkg;

  typedef enum logic [2:0] {
    MA_IDLE   = 3'd0,
    MA_REQ    = 3'd1,
    MA_WAIT   = 3'd2,
    MA_DONE   = 3'd3,
    MA_CANCEL = 3'd4
  } ma_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/ma_store_fmt.sv
// rtl/ma_store_fmt.sv - lane mask to bus size and lane-replicated store data
//
// Purpose: purely combinational formatting of store data for the data bus.
// Ports:
//   i_lsv   in  4   low-aligned lane mask (0001 byte, 0011 half, 1111 word)
//   i_wdata in  32  low-aligned store data
//   o_size  out 2   bus size code (SZ_BYTE/SZ_HALF/SZ_WORD)
//   o_wdata out 32  store data replicated across all lanes of its size

module ma_store_fmt
  import mem_access_pkg::*;
(
  input  logic [3:0]  i_lsv,
  input  logic [31:0] i_wdata,
  output logic [1:0]  o_size,
  output logic [31:0] o_wdata
);

  // Only the top bit of each mask width decides the size; the other bits are redundant.
  logic w_unused_lsv;
  assign w_unused_lsv = i_lsv[2] ^ i_lsv[0];

  assign o_size = i_lsv[3] ? SZ_WORD : (i_lsv[1] ? SZ_HALF : SZ_BYTE);

  // Replication lets the slave pick the byte lanes from addr[1:0] without a shifter here.
  always_comb begin
    o_wdata = i_wdata;
    case (o_size)
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage data-side load/store access unit
//
// Purpose: issues one load/store per MEM instruction on the SRAM-like data bus,
// stalls MEM until the access completes and holds the raw read word for WB.
// Non-memory instructions pass straight through. A flushed access drains and is dropped.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   mem_valid/load/store        MEM instruction qualifiers
//   mem_lsV, mem_addr, mem_wdata  lane mask, effective address, low-aligned store data
//   flush                       exception/eret flush of MEM and younger
//   out_ready                   WB can accept
//   data_req/wr/size/addr/wdata bus request side
//   data_addr_ok/data_ok/rdata  bus response side
//   mem_stall                   MEM must hold its inputs
//   out_valid, out_rdata        result to WB (raw word, WB aligns)

module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [3:0]  mem_lsV,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  input  logic        out_ready,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic        out_valid,
  output logic [31:0] out_rdata
);

  ma_state_e   r_state;
  ma_state_e   w_next;
  logic [31:0] r_rdata;
  logic        w_cap;
  logic        w_op;
  logic        w_go;

  // Gating with resetn makes the request/stall/valid outputs drop the moment reset asserts,
  // even though MEM may still be presenting a valid instruction.
  assign w_op = resetn & mem_valid & (mem_load | mem_store);
  assign w_go = w_op & ~flush;

  // Request attributes come straight from MEM; mem_stall keeps them stable while outstanding.
  assign data_wr   = mem_store;
  assign data_addr = mem_addr;

  ma_store_fmt u_store_fmt (
    .i_lsv   (mem_lsV),
    .i_wdata (mem_wdata),
    .o_size  (data_size),
    .o_wdata (data_wdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= MA_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap) begin
        r_rdata <= data_rdata;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    data_req  = 1'b0;
    out_valid = 1'b0;
    out_rdata = r_rdata;
    w_cap     = 1'b0;
    case (r_state)
      MA_IDLE: begin
        if (w_go) begin
          data_req = 1'b1;
          w_next   = data_addr_ok ? MA_WAIT : MA_REQ;
        end else if (!w_op) begin
          out_valid = resetn & mem_valid & ~flush;
        end
      end
      MA_REQ: begin
        // Once raised, the request is held until accepted, even across a flush.
        data_req = 1'b1;
        if (data_addr_ok) begin
          w_next = flush ? MA_CANCEL : MA_WAIT;
        end
      end
      MA_WAIT: begin
        if (data_data_ok) begin
          w_cap = 1'b1;
          if (flush) begin
            w_next = MA_IDLE;
          end else begin
            // Bypass the returning word so a ready WB sees it in the data_ok cycle.
            out_valid = 1'b1;
            out_rdata = data_rdata;
            w_next    = out_ready ? MA_IDLE : MA_DONE;
          end
        end else if (flush) begin
          w_next = MA_CANCEL;
        end
      end
      MA_DONE: begin
        if (flush) begin
          w_next = MA_IDLE;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            w_next = MA_IDLE;
          end
        end
      end
      MA_CANCEL: begin
        // The orphaned transaction must finish on the bus before a new one may start.
        if (data_data_ok) begin
          w_next = MA_IDLE;
        end
      end
      default: w_next = MA_IDLE;
    endcase
  end

  assign mem_stall = (w_go & ~(out_valid & out_ready)) | (r_state == MA_CANCEL);

endmodule
